axi_read_responder: RTL and testbench
=====================================

// Module: axi_read_responder
// PURPOSE
//  AXI3/AXI4 read-channel slave: accepts one AR request at a time and returns the burst on R from an internal word RAM.
//  It is the responder end of the burst reads issued by the icache refill path and the instruction prefetch buffer.
//  It serves as the memory model in cache/prefetch benches and as an on-chip boot/ROM slave behind the arbiter.
//  The AW/W/B channels are not part of this block.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words in the RAM (power of 2); word index = araddr[$clog2(DEPTH)+1:2]
//  LATENCY  2     idle cycles between the AR handshake and the first rvalid (0..15)
//  ID_W     4     width of arid/rid
// PORTS
//  clk       in   1      clock; all logic on rising edge
//  rst       in   1      reset, asynchronous, active-high
//  arid      in   ID_W   request id; echoed on rid
//  araddr    in   32     byte address of the first beat
//  arlen     in   8      beats-1
//  arsize    in   3      only 3'd2 (4 B) is supported
//  arburst   in   2      00 FIXED, 01 INCR, 10 WRAP
//  arvalid   in   1      request valid
//  arready   out  1      request accepted this cycle when arvalid&&arready
//  rid       out  ID_W   id of the current burst
//  rdata     out  32     beat data
//  rresp     out  2      00 OKAY, 10 SLVERR
//  rlast     out  1      final beat of the burst
//  rvalid    out  1      beat valid
//  rready    in   1      master accepts the beat
//  mem_we    in   1      preload write strobe (bench/boot loader)
//  mem_waddr in   $clog2(DEPTH)  preload word index
//  mem_wdata in   32     preload data
//  busy      out  1      a burst is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs are registered and reset to 0, including arready. While rst is high the FSM is IDLE and no beat is pending.
//  arready = 1 only in IDLE. It first rises on the cycle after rst deasserts. One request is outstanding at a time.
//  FSM states are IDLE, WAIT and BURST.
//   IDLE: on arvalid&&arready, latch id, address, len, size and burst.
//         Go to WAIT if LATENCY > 0; otherwise go straight to BURST.
//   WAIT: a counter loads LATENCY-1 and decrements to 0, then the FSM goes to BURST.
//   BURST: the beat register holds rdata/rresp/rlast/rid with rvalid = 1.
//          On rvalid&&rready the next beat loads in the same cycle, so a held-high rready gives 1 beat/clk.
//          The beat with rlast=1 accepted -> IDLE. arready returns to 1 on the next cycle.
//  Timing: AR handshake at edge T puts the first rvalid at edge T+1+LATENCY.
//  Back-pressure: while rvalid && !rready, rid/rdata/rresp/rlast stay stable.
//  Beat counter is 8-bit. rlast = (count == len). arlen = 0 gives a single beat with rlast = 1.
//  Addressing (word-granular, byte addr[1:0] ignored):
//   FIXED: every beat reads the same word.
//   INCR: addr += 4 per beat. The word index wraps modulo DEPTH. 4 KB crossings are not checked.
//   WRAP: legal for len in {1,3,7,15}. The container is (len+1)*4 B, aligned.
//         addr = base | ((addr+4) & (size-1)), e.g. start 0x1C with len 7 reads 0x1C,0x00,0x04..0x18.
//  Errors: arsize != 2, arburst == 11, or WRAP with an illegal len -> every beat returns rresp = SLVERR and rdata = 0.
//          The burst still runs the full len+1 beats. Error bursts use INCR addressing.
//  RAM: rdata is sampled from the RAM when a beat loads into the output register.
//       A mem_we to the same word in that cycle is not seen; the old data is returned.
//       mem_we is accepted in every state.
//  Async rst mid-burst: rvalid drops immediately, the burst is abandoned, and the RAM contents are retained.
//  arvalid while busy: ignored (arready = 0). The master must hold the request.
// STRUCTURE
//  Shared package axi_pkg holds:
//   BURST_FIXED/INCR/WRAP (2'b00/01/10)
//   RESP_OKAY/SLVERR (2'b00/10)
//   typedef ar_req_t {id, addr, len, size, burst}
//   typedef rd_state_e {IDLE, WAIT, BURST}
//  One sub-module, axi_burst_addr_gen: combinational next-address from (addr, len, burst).
//  It is reused by the future write responder.
//  The RAM is an inferred reg array with one synchronous write port and one read port.
// TESTING
//  1. Preload word[i] = 0x1000_0000+i. INCR araddr=0x40, arlen=7, LATENCY=2, rready=1.
//     -> first rvalid 3 cycles after the handshake, data 0x1000_0010..0x1000_0017 on 8 consecutive clocks, rlast on beat 8.
//  2. WRAP araddr=0x1C, arlen=7 -> words 7,0,1,...,6 in that order, all rresp = OKAY.
//  3. INCR len 3 with rready toggled 1,0,0,1,... -> no beat lost or duplicated, outputs stable while stalled, 4 beats total.
//  4. arsize=1, arlen=2 -> 3 beats with rresp = SLVERR and rdata = 0. arburst=11 gives the same result.
//  5. rst asserted on beat 3 of 8 -> rvalid = 0 the same cycle. arready = 1 the cycle after release. A new INCR request completes correctly.
//  6. arlen=0 FIXED, arid=4'hA, with a mem_we to the same word on the beat-load cycle -> one beat, rid = A, rlast = 1, old data returned.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read/write responder definitions: burst/response encodings,
// the latched AR request record and the read responder FSM states.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'd2;

  // Widest id any responder instance may use; instances keep the low ID_W bits.
  localparam int ID_MAX_W = 16;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } ar_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} rd_state_e;

  // Requests the responder cannot honour are answered with SLVERR beats.
  function automatic logic req_is_err(input ar_req_t r);
    return (r.size != SIZE_4B) || (r.burst == 2'b11) ||
           ((r.burst == BURST_WRAP) && !(r.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for 4-byte AXI beats (FIXED / INCR / WRAP).
// Shared between the read responder and the write responder.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  always_comb begin
    incr_addr = addr + 32'd4;
    // Wrap container is (len+1) beats of 4 bytes, naturally aligned.
    wrap_mask = ((32'(len) + 32'd1) << 2) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI read-channel slave: one AR request at a time, burst returned on R from
// an internal word RAM that is preloaded through a separate write port.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ID_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          arid,
  input  logic [31:0]              araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_W-1:0]          rid,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [31:0]              mem_wdata,
  output logic                     busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  rd_state_e       state_q, state_d;
  ar_req_t         req_q, req_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;
  logic            rvalid_q, rvalid_d;
  logic            arready_q, arready_d;
  logic            busy_q, busy_d;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_rdata;
  logic [31:0]     next_addr;
  logic [1:0]      gen_burst;
  logic            req_err;
  logic            ar_hs, r_hs, last_hs, beat_load;
  logic            unused_id_bits;

  assign ar_hs          = arvalid && arready_q;
  assign r_hs           = rvalid_q && rready;
  assign last_hs        = r_hs && rlast_q;
  assign req_err        = req_is_err(req_q);
  assign gen_burst      = req_err ? BURST_INCR : req_q.burst;
  assign mem_rdata      = mem_q[req_q.addr[AW+1:2]];
  assign unused_id_bits = ^req_q.id;
  // A beat loads whenever the output register is empty or being drained,
  // until the rlast beat has been loaded.
  assign beat_load = (state_q == BURST) && !last_hs && (!rvalid_q || rready);

  axi_burst_addr_gen u_addr_gen (
    .addr      (req_q.addr),
    .len       (req_q.len),
    .burst     (gen_burst),
    .next_addr (next_addr)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; always_comb uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = (LATENCY > 0) ? WAIT : BURST;
      WAIT:    if (wait_cnt_q == 4'd0) state_d = BURST;
      BURST:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    arready_d  = (state_d == IDLE);
    busy_d     = (state_d != IDLE);

    if (state_q == IDLE && ar_hs) begin
      req_d      = '{id: ID_MAX_W'(arid), addr: araddr, len: arlen,
                     size: arsize, burst: arburst};
      wait_cnt_d = WAIT_INIT;
      beat_cnt_d = 8'd0;
    end

    if (state_q == WAIT && wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;

    if (state_q == BURST && last_hs) rvalid_d = 1'b0;

    if (beat_load) begin
      rid_d      = req_q.id[ID_W-1:0];
      rdata_d    = req_err ? 32'd0 : mem_rdata;
      rresp_d    = req_err ? RESP_SLVERR : RESP_OKAY;
      rlast_d    = (beat_cnt_q == req_q.len);
      rvalid_d   = 1'b1;
      req_d.addr = next_addr;
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      req_q      <= req_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: the RAM has no reset, so it maps onto block RAM and its contents
  // survive rst; a same-cycle write is not visible to a beat loading now.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: vector table of AR requests,
// scoreboard of expected R beats, plus reset and RAM-collision sequences.
module tb_axi_read_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int ID_W    = 4;
  localparam int AW      = $clog2(DEPTH);
  localparam int BUDGET  = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic            busy;

  always #5 clk = ~clk;

  axi_read_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy)
  );

  // mode: 0 = rready held high, 1 = rready pattern 1,0,0,1, 2 = random rready
  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    int              mode;
    logic [1:0]      exp_resp;
  } vec_t;

  typedef struct {
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] model_mem [DEPTH];
  vec_t        vecs [10];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Word read by beat i, derived from the container arithmetic of each burst type.
  function automatic int unsigned beat_index(input vec_t v, input int i);
    int unsigned w, n, base;
    w = int'(v.addr >> 2) % DEPTH;
    if (v.exp_resp == 2'b10 || v.burst == 2'b01) return (w + i) % DEPTH;
    if (v.burst == 2'b00) return w;
    n    = int'(v.len) + 1;
    base = (w / n) * n;
    return base + ((w - base + i) % n);
  endfunction

  task automatic run_burst(input vec_t v, input int abort_at, input bit we_at_load);
    beat_t       b;
    int          j, accepted, guard;
    bit          first_seen;
    int unsigned load_idx;
    for (int i = 0; i <= int'(v.len); i++) begin
      b.rid   = v.id;
      b.rdata = (v.exp_resp == 2'b10) ? 32'd0 : model_mem[beat_index(v, i)];
      b.rresp = v.exp_resp;
      b.rlast = (i == int'(v.len));
      sb.push_back(b);
    end
    load_idx = beat_index(v, 0);

    @(negedge clk);
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1;
    guard = 0;
    while (arready !== 1'b1 && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= BUDGET) begin
      check("arready_timeout", arready, 1);
      sb.delete();
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    j = 0; accepted = 0; first_seen = 1'b0;

    while (sb.size() > 0 && j < BUDGET) begin
      if (we_at_load && j == LATENCY) begin
        mem_we    = 1'b1;
        mem_waddr = load_idx[AW-1:0];
        mem_wdata = ~model_mem[load_idx];
      end else begin
        mem_we = 1'b0;
      end
      case (v.mode)
        0:       rready = 1'b1;
        1:       rready = (j % 4 == 0) || (j % 4 == 3);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rvalid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          check("first_rvalid_latency", j, 1 + LATENCY);
          check("arready_while_busy", arready, 0);
        end
        check("rid", rid, sb[0].rid);
        check("rdata", rdata, sb[0].rdata);
        check("rresp", rresp, sb[0].rresp);
        check("rlast", rlast, sb[0].rlast);
        if (abort_at != 0 && accepted + 1 == abort_at) begin
          rst = 1'b1;
          #1;
          check("rvalid_async_rst", rvalid, 0);
          check("busy_async_rst", busy, 0);
          check("arready_async_rst", arready, 0);
          sb.delete();
          mem_we = 1'b0;
          rready = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          check("arready_at_release", arready, 0);
          @(negedge clk);
          check("arready_after_release", arready, 1);
          return;
        end
        if (rready) begin
          void'(sb.pop_front());
          accepted++;
        end
      end else if (first_seen && v.mode == 0) begin
        check("rvalid_gap", rvalid, 1);
      end
      @(negedge clk);
      j++;
    end
    mem_we = 1'b0;
    if (sb.size() > 0) begin
      check("burst_timeout_beats_left", sb.size(), 0);
      sb.delete();
    end else begin
      check("rvalid_after_last", rvalid, 0);
      check("busy_after_last", busy, 0);
      check("arready_after_last", arready, 1);
    end
    if (we_at_load) model_mem[load_idx] = ~model_mem[load_idx];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    vecs[0] = '{4'h1, 32'h0000_0040, 8'd7,  3'd2, 2'b01, 0, 2'b00};
    vecs[1] = '{4'h2, 32'h0000_001C, 8'd7,  3'd2, 2'b10, 0, 2'b00};
    vecs[2] = '{4'h3, 32'h0000_0010, 8'd3,  3'd2, 2'b01, 1, 2'b00};
    vecs[3] = '{4'h4, 32'h0000_0000, 8'd2,  3'd1, 2'b01, 0, 2'b10};
    vecs[4] = '{4'h5, 32'h0000_0000, 8'd2,  3'd2, 2'b11, 0, 2'b10};
    vecs[5] = '{4'h6, 32'h0000_0008, 8'd3,  3'd2, 2'b10, 2, 2'b00};
    vecs[6] = '{4'h7, 32'h0000_0030, 8'd4,  3'd2, 2'b10, 0, 2'b10};
    vecs[7] = '{4'h8, 32'h0000_0FF8, 8'd3,  3'd2, 2'b01, 1, 2'b00};
    vecs[8] = '{4'h9, 32'h0000_0022, 8'd3,  3'd2, 2'b00, 2, 2'b00};
    vecs[9] = '{4'hF, 32'h0000_003C, 8'd15, 3'd2, 2'b10, 2, 2'b00};

    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_arready", arready, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_busy", busy, 0);
    check("reset_rlast", rlast, 0);
    check("reset_rdata", rdata, 0);
    rst = 1'b0;
    check("arready_before_first_edge", arready, 0);
    @(negedge clk);
    check("arready_first_rise", arready, 1);

    for (int i = 0; i < DEPTH; i++) begin
      mem_we       = 1'b1;
      mem_waddr    = AW'(i);
      mem_wdata    = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
      @(negedge clk);
    end
    mem_we = 1'b0;

    for (int i = 0; i < 10; i++) run_burst(vecs[i], 0, 1'b0);

    // Reset while the third of eight beats is presented, then a clean burst.
    v = '{4'hC, 32'h0000_0100, 8'd7, 3'd2, 2'b01, 0, 2'b00};
    run_burst(v, 3, 1'b0);
    v = '{4'hD, 32'h0000_0200, 8'd7, 3'd2, 2'b01, 0, 2'b00};
    run_burst(v, 0, 1'b0);

    // Single FIXED beat colliding with a preload write, then read the new word.
    v = '{4'hA, 32'h0000_0050, 8'd0, 3'd2, 2'b00, 0, 2'b00};
    run_burst(v, 0, 1'b1);
    run_burst(v, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
